// File: rtl/gumnut_data_mem_responder.sv
// Gumnut data-bus target: byte-wide synchronous RAM that answers ldm/stm requests
// with a one-cycle ack after WAIT_STATES (plus any stall) wait cycles.
module gumnut_data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [7:0]        dat_i,
    input  logic              stall_i,
    output logic [7:0]        dat_o,
    output logic              ack_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [7:0]          wdat_q, wdat_d;
    logic [7:0]          dat_q, dat_d;
    logic                commit;
    logic                req;

    logic [7:0]          ram_q [2**ADDR_W];

    assign req = cyc_i & stb_i;

    // commit marks the edge that enters ACK; the *_d request fields hold the
    // bus values when ACK is entered straight from IDLE (WAIT_STATES == 0).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = we_i;
                    adr_d  = adr_i;
                    wdat_d = dat_i;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_STATES == 0 && !stall_i) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (!stall_i) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dat_d = dat_q;
        if (commit && !we_d) begin
            dat_d = ram_q[adr_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= 8'h00;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            dat_q   <= dat_d;
        end
    end

    // A write whose commit edge coincides with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (commit && we_d && !rst_i) begin
            ram_q[adr_d] <= wdat_d;
        end
    end

    assign dat_o  = dat_q;
    assign ack_o  = (state_q == ST_ACK);
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gumnut_data_mem_responder.sv
// Bench for gumnut_data_mem_responder: two instances (WAIT_STATES 0 and 1) share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_gumnut_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst, cyc, stb, we, stall;
    logic [7:0] adr, dat;
    logic [7:0] dout [2];
    logic       ack  [2];
    logic       busy [2];

    always #5 clk = ~clk;

    gumnut_data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .stall_i(stall),
        .dat_o(dout[0]), .ack_o(ack[0]), .busy_o(busy[0])
    );

    gumnut_data_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .stall_i(stall),
        .dat_o(dout[1]), .ack_o(ack[1]), .busy_o(busy[1])
    );

    // Model: a request is "pending" from acceptance until it has seen enough
    // unstalled cycles; the ack cycle follows; memory is a plain byte array.
    bit         m_pend  [2];
    bit         m_ack   [2];
    int         m_el    [2];
    int         m_need  [2];
    bit         m_we    [2];
    logic [7:0] m_adr   [2];
    logic [7:0] m_dat   [2];
    logic [7:0] mem     [2][256];
    bit         known   [2][256];
    logic [7:0] e_dat   [2];
    bit         e_known [2];
    bit         model_on = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_commit(input int k);
        if (m_we[k]) begin
            mem[k][m_adr[k]]   = m_dat[k];
            known[k][m_adr[k]] = 1'b1;
        end else begin
            e_dat[k]   = mem[k][m_adr[k]];
            e_known[k] = known[k][m_adr[k]];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_ack[k]   = 1'b0;
            e_dat[k]   = 8'h00;
            e_known[k] = 1'b1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_ack[k]) begin
                m_ack[k] = 1'b0;
            end else if (!m_pend[k]) begin
                if (cyc && stb) begin
                    m_we[k]  = we;
                    m_adr[k] = adr;
                    m_dat[k] = dat;
                    if (ws_of(k) == 0 && !stall) begin
                        model_commit(k);
                        m_ack[k] = 1'b1;
                    end else begin
                        m_pend[k] = 1'b1;
                        m_el[k]   = 0;
                        m_need[k] = (ws_of(k) == 0) ? 1 : ws_of(k);
                    end
                end
            end else if (!(cyc && stb)) begin
                m_pend[k] = 1'b0;
            end else if (!stall) begin
                m_el[k]++;
                if (m_el[k] >= m_need[k]) begin
                    m_pend[k] = 1'b0;
                    m_ack[k]  = 1'b1;
                    model_commit(k);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        model_on = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Runs one transfer until the WAIT_STATES=1 instance acks (bounded), then idles.
    task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = ack[1];
        end
        check("xfer_ack", ack[1], 1);
        cyc = 1'b0; stb = 1'b0;
        tick();
        tick();
    endtask

    // Compare process: every cycle, every output of both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on && !rst) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("ack_ws%0d", ws_of(k)), ack[k], m_ack[k]);
                    check($sformatf("busy_ws%0d", ws_of(k)), busy[k], m_pend[k] | m_ack[k]);
                    if (e_known[k])
                        check($sformatf("dat_ws%0d", ws_of(k)), dout[k], e_dat[k]);
                    if (ack[k])
                        $display("xfer ws=%0d we=%0b adr=%02h wdat=%02h dat_o=%02h",
                                 ws_of(k), m_we[k], m_adr[k], m_dat[k], dout[k]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) known[k][a] = 1'b0;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; stall = 1'b0;
        adr = 8'h00; dat = 8'h00;
        #1;
        do_reset();
        check("rst_ack", ack[1], 0);
        check("rst_busy", busy[1], 0);
        check("rst_dat", dout[1], 8'h00);

        // Write 10=A5: ack in cycle 2 only
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10; dat = 8'hA5;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("wr_ack_cycle", ack[1], (c == 2));
            check("wr_busy_cycle", busy[1], (c <= 2));
            if (c == 2) begin cyc = 1'b0; stb = 1'b0; end
        end

        // Read 10: ack in cycle 2 with A5
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("rd_ack_cycle", ack[1], (c == 2));
            check("rd_busy_cycle", busy[1], (c <= 2));
            if (c == 2) begin
                check("rd_dat", dout[1], 8'hA5);
                cyc = 1'b0; stb = 1'b0;
            end
        end
        tick();

        // Read 10 with three stall cycles after acceptance: ack moves to cycle 5
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("stall_ack_cycle", ack[1], (c == 5));
            if (c == 1) stall = 1'b1;
            if (c == 4) stall = 1'b0;
            if (c == 5) begin
                check("stall_dat", dout[1], 8'hA5);
                cyc = 1'b0; stb = 1'b0;
            end
        end
        tick();
        tick();

        // Abort: preload 20=00, start write 20=3C, drop stb in WAIT
        xfer(1'b1, 8'h20, 8'h00);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h20; dat = 8'h3C;
        tick();
        check("abort_busy_wait", busy[1], 1);
        stb = 1'b0;
        tick();
        check("abort_ack", ack[1], 0);
        check("abort_idle", busy[1], 0);
        cyc = 1'b0;
        tick();
        xfer(1'b0, 8'h20, 8'h00);
        check("abort_rd_dat", dout[1], 8'h00);

        // Back-to-back writes FF=01 then 00=02 with strobe held
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'hFF; dat = 8'h01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("b2b_ack_cycle", ack[1], (c == 2 || c == 5));
            if (c == 2) begin adr = 8'h00; dat = 8'h02; end
            if (c == 5) begin cyc = 1'b0; stb = 1'b0; end
        end
        tick();
        tick();
        xfer(1'b0, 8'hFF, 8'h00);
        check("b2b_rd_ff", dout[1], 8'h01);
        xfer(1'b0, 8'h00, 8'h00);
        check("b2b_rd_00", dout[1], 8'h02);

        // Reset during WAIT of write 40=77 after preload 40=11
        xfer(1'b1, 8'h40, 8'h11);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h40; dat = 8'h77;
        tick();
        check("rstw_busy_pre", busy[1], 1);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("rstw_ack", ack[1], 0);
        check("rstw_busy", busy[1], 0);
        check("rstw_dat", dout[1], 8'h00);
        #1;
        rst = 1'b0;
        tick();
        xfer(1'b0, 8'h40, 8'h00);
        check("rstw_rd_dat", dout[1], 8'h11);

        // WAIT_STATES=0 instance: read 10 acks in cycle 1
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
        tick();
        check("ws0_ack_c1", ack[0], 1);
        check("ws0_dat_c1", dout[0], 8'hA5);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("ws0_ack_c2", ack[0], 0);
        check("ws0_busy_c2", busy[0], 0);
        tick();

        // Randomized traffic on a small address window plus the wrap corner
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                cyc = ($urandom_range(0, 4) != 0);
                stb = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 9) < 3)
                adr = 8'($urandom_range(0, 15)) ^ (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
            if ($urandom_range(0, 9) < 3) we = 1'($urandom_range(0, 1));
            dat   = 8'($urandom_range(0, 255));
            stall = ($urandom_range(0, 4) == 0);
        end
        cyc = 1'b0; stb = 1'b0; stall = 1'b0;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gumnut_data_mem_responder.md
Name: gumnut_data_mem_responder

Overview:
- Data-memory responder on the Gumnut data bus: the target end of the handshake the control FSM waits on in its execute and mem states.
- Accepts ldm/stm requests (cyc/stb/we/adr/dat) from the core.
- Holds a synchronous 2^ADDR_W x 8 RAM.
- Returns a single-cycle ack_o after a configurable, optionally stall-extended, number of wait states. This exercises the core's mem_state wait loop.

Parameters:
- ADDR_W, 8: address width; RAM depth is 2^ADDR_W bytes.
- WAIT_STATES, 1: fixed wait cycles inserted before ack_o; legal range 0..15; 4-bit counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- cyc_i  in  1  bus cycle valid, from core.
- stb_i  in  1  strobe; a request is present when cyc_i & stb_i.
- we_i  in  1  1 = write (stm), 0 = read (ldm).
- adr_i  in  ADDR_W  byte address.
- dat_i  in  8  write data.
- stall_i  in  1  test/throttle input; while high, the wait counter holds and ack is withheld.
- dat_o  out  8  read data; valid when ack_o=1 on a read.
- ack_o  out  1  single-cycle acknowledge.
- busy_o  out  1  high while a request has been accepted and not yet acked.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: state=IDLE, wait counter=0, ack_o=0, busy_o=0, dat_o=8'h00. RAM contents are not cleared (undefined until written).
- Request capture: we_i, adr_i and dat_i are captured into internal registers on the accepting edge. Changes on the bus after acceptance are ignored.
- FSM states: IDLE, WAIT, ACK. ack_o=1 only in ACK; busy_o=1 in WAIT and ACK.
- IDLE:
  - If cyc_i&stb_i at the edge, capture the request and load counter=WAIT_STATES.
  - If WAIT_STATES=0 and stall_i=0, go to ACK; otherwise go to WAIT.
- WAIT:
  - If cyc_i=0 or stb_i=0, abort: go to IDLE, no RAM write, no ack, dat_o unchanged.
  - Else if stall_i=1, hold state and counter.
  - Else if counter<=1, go to ACK.
  - Else decrement counter.
- ACK:
  - Lasts exactly one cycle.
  - Write: RAM[adr] <= dat is committed on the edge that enters ACK.
  - Read: dat_o <= RAM[adr] is loaded on the edge that enters ACK, so it is valid during the ack_o cycle. dat_o holds until the next read ack; writes do not change dat_o.
  - Next state is always IDLE.
- Latency: a request first present in cycle N with no stall gives ack_o high in cycle N+1+WAIT_STATES. Each stall cycle adds one cycle.
- Back-to-back: the earliest a second request can be accepted is the cycle after ACK, in IDLE. ack_o is never high in two consecutive cycles, so a single strobe cannot produce a double write.
- Abort in IDLE: a strobe that drops before being accepted has no effect.
- Reset mid-operation: rst_i in WAIT or ACK returns to IDLE immediately with ack_o=0. A pending write is discarded unless its commit edge already occurred.
- Address width: addresses wrap naturally modulo 2^ADDR_W; there is no out-of-range case.
- Signals in ACK: cyc_i and stb_i are ignored in ACK; the ack completes regardless.

Test Plan:
- Reset, then write adr=8'h10 dat=8'hA5 with WAIT_STATES=1 and strobe asserted in cycle 0 -> ack_o high in cycle 2 only. A following read of 8'h10 -> ack in its cycle 2 with dat_o=8'hA5; busy_o high in cycles 1-2.
- Read 8'h10 with stall_i high for 3 cycles after acceptance -> ack delayed from cycle 2 to cycle 5; dat_o=8'hA5 in the ack cycle.
- Write 8'h20=8'h3C, then drop stb_i during WAIT -> no ack_o, FSM in IDLE next cycle. A subsequent read of 8'h20 returns the previously written value (8'h00 after a preload write of 8'h00).
- Back-to-back writes 8'hFF=8'h01 then 8'h00=8'h02 with stb held high continuously -> two distinct acks separated by the IDLE cycle. Reads then return 8'h01 and 8'h02, confirming the address boundaries.
- Assert rst_i during WAIT of a write of 8'h40=8'h77 -> ack_o=0, busy_o=0, dat_o=8'h00 immediately. A read of 8'h40 after a preload of 8'h11 returns 8'h11.
- WAIT_STATES=0 variant: read request in cycle 0 -> ack_o in cycle 1; WAIT is never entered unless stall_i is high.
